// File: rtl/z_run_length_reporter.sv
// Measures each run of z=1 in cycles, counts runs, and reports lengths through a one-entry Valid/Ack buffer.
// Latency: RunLen and Valid update on the edge that samples z=0. A completed run that finds the buffer full is dropped and sets the sticky Overflow.
// Optional ZRUN_ALARM_EN adds a registered Alarm that is raised once a run reaches ALARM_LEN cycles.
module z_run_length_reporter #(
  parameter int LW        = 8,
  parameter int CW        = 16,
  parameter int ALARM_LEN = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          z,
  input  logic          Ack,
  output logic          Valid,
  output logic [LW-1:0] RunLen,
  output logic [CW-1:0] EventCount,
  output logic          Busy,
  output logic          Overflow
`ifdef ZRUN_ALARM_EN
  ,
  output logic          Alarm
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] run_cnt, run_cnt_nxt;
  logic          run_start, run_end, buf_free;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (z)  state_nxt = RUN;
      RUN:     if (!z) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The buffer is free when empty, or when the reader consumes it on this same edge.
  always_comb begin
    run_start   = (state == IDLE) && z;
    run_end     = (state == RUN) && !z;
    buf_free    = !Valid || Ack;
    run_cnt_nxt = run_cnt;
    if (run_start)
      run_cnt_nxt = {{(LW-1){1'b0}}, 1'b1};
    else if ((state == RUN) && z && (run_cnt != {LW{1'b1}}))
      run_cnt_nxt = run_cnt + 1'b1;
  end

  assign Busy = (state == RUN);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      run_cnt    <= '0;
      Valid      <= 1'b0;
      RunLen     <= '0;
      EventCount <= '0;
      Overflow   <= 1'b0;
    end else begin
      run_cnt <= run_cnt_nxt;
      if (run_start)
        EventCount <= EventCount + 1'b1;
      if (run_end && buf_free) begin
        RunLen <= run_cnt;
        Valid  <= 1'b1;
      end else if (run_end) begin
        Overflow <= 1'b1;
      end else if (Valid && Ack) begin
        Valid <= 1'b0;
      end
    end
  end

`ifdef ZRUN_ALARM_EN
  // A threshold the counter cannot represent never fires.
  localparam bit            ALARM_OK  = (ALARM_LEN >= 1) && (ALARM_LEN <= (2**LW - 1));
  localparam logic [LW-1:0] ALARM_CNT = LW'(ALARM_LEN);

  always_ff @(posedge Clock) begin
    if (Reset)
      Alarm <= 1'b0;
    else if (state_nxt != RUN)
      Alarm <= 1'b0;
    else if (ALARM_OK && (run_cnt_nxt == ALARM_CNT))
      Alarm <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_z_run_length_reporter.sv
// Scenario-driven bench for z_run_length_reporter; expected run lengths queued at stimulus time.
module tb_z_run_length_reporter;

  logic        Clock = 1'b0;
  logic        Reset, z, Ack;
  logic        Valid, Busy, Overflow;
  logic [7:0]  RunLen;
  logic [15:0] EventCount;

  logic        Reset2, z2, Ack2;
  logic        Valid2, Busy2, Overflow2;
  logic [7:0]  RunLen2;
  logic [3:0]  EventCount2;
`ifdef ZRUN_ALARM_EN
  logic        Alarm, Alarm2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_len;

  always #5 Clock = ~Clock;

  z_run_length_reporter #(.LW(8), .CW(16), .ALARM_LEN(16)) dut (
    .Clock(Clock), .Reset(Reset), .z(z), .Ack(Ack),
    .Valid(Valid), .RunLen(RunLen), .EventCount(EventCount),
    .Busy(Busy), .Overflow(Overflow)
`ifdef ZRUN_ALARM_EN
    , .Alarm(Alarm)
`endif
  );

  z_run_length_reporter #(.LW(8), .CW(4), .ALARM_LEN(16)) dut_w (
    .Clock(Clock), .Reset(Reset2), .z(z2), .Ack(Ack2),
    .Valid(Valid2), .RunLen(RunLen2), .EventCount(EventCount2),
    .Busy(Busy2), .Overflow(Overflow2)
`ifdef ZRUN_ALARM_EN
    , .Alarm(Alarm2)
`endif
  );

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; z = 1'b0; Ack = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  // Drives n samples of z=1 then one z=0 sample (the run-end edge).
  task automatic drive_run(input int n);
    z = 1'b1;
    repeat (n) tick();
    z = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({Valid, RunLen, EventCount, Busy, Overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got V=%0b R=%0d E=%0d B=%0b O=%0b want all 0",
               Valid, RunLen, EventCount, Busy, Overflow);
    end
  endtask

  task automatic test_single_run();
    do_reset();
    exp_q.push_back(3);
    drive_run(3);
    exp_len = exp_q.pop_front();
    n_checks++;
    if (Valid !== 1'b1 || RunLen !== 8'(exp_len)) begin
      n_fail++;
      $display("FAIL single_run: got V=%0b R=%0d want V=1 R=%0d", Valid, RunLen, exp_len);
    end
    n_checks++;
    if (EventCount !== 16'd1 || Busy !== 1'b0 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_run_status: got E=%0d B=%0b O=%0b want E=1 B=0 O=0",
               EventCount, Busy, Overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    exp_q.push_back(2);
    drive_run(2);
    drive_run(4);
    exp_len = exp_q.pop_front();
    n_checks++;
    if (RunLen !== 8'(exp_len) || Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_hold: got V=%0b R=%0d want V=1 R=%0d", Valid, RunLen, exp_len);
    end
    n_checks++;
    if (Overflow !== 1'b1 || EventCount !== 16'd2) begin
      n_fail++;
      $display("FAIL overflow_flag: got O=%0b E=%0d want O=1 E=2", Overflow, EventCount);
    end
    Ack = 1'b1; tick(); Ack = 1'b0; tick();
    n_checks++;
    if (Overflow !== 1'b1 || Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_sticky: got O=%0b V=%0b want O=1 V=0", Overflow, Valid);
    end
  endtask

  task automatic test_saturation();
    int busy_bad;
    busy_bad = 0;
    do_reset();
    exp_q.push_back(255);
    z = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (Busy !== 1'b1) busy_bad++;
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL saturate_busy: got %0d cycles with Busy=0 want 0", busy_bad);
    end
    z = 1'b0;
    tick();
    exp_len = exp_q.pop_front();
    n_checks++;
    if (RunLen !== 8'(exp_len) || Valid !== 1'b1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL saturate_len: got R=%0d V=%0b B=%0b want R=%0d V=1 B=0",
               RunLen, Valid, Busy, exp_len);
    end
    n_checks++;
    if (EventCount !== 16'd1) begin
      n_fail++;
      $display("FAIL saturate_count: got E=%0d want 1", EventCount);
    end
  endtask

  task automatic test_ack_reload();
    do_reset();
    exp_q.push_back(2);
    drive_run(2);
    exp_len = exp_q.pop_front();
    n_checks++;
    if (RunLen !== 8'(exp_len) || Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_first: got V=%0b R=%0d want V=1 R=%0d", Valid, RunLen, exp_len);
    end
    exp_q.push_back(5);
    z = 1'b1;
    repeat (5) tick();
    z = 1'b0; Ack = 1'b1;
    tick();
    Ack = 1'b0;
    exp_len = exp_q.pop_front();
    n_checks++;
    if (RunLen !== 8'(exp_len) || Valid !== 1'b1 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_same_edge: got V=%0b R=%0d O=%0b want V=1 R=%0d O=0",
               Valid, RunLen, Overflow, exp_len);
    end
    Ack = 1'b1; tick(); Ack = 1'b0;
    n_checks++;
    if (Valid !== 1'b0 || RunLen !== 8'd5) begin
      n_fail++;
      $display("FAIL ack_consume: got V=%0b R=%0d want V=0 R=5", Valid, RunLen);
    end
    Ack = 1'b1; tick(); Ack = 1'b0;
    n_checks++;
    if (Valid !== 1'b0 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_idle_ignored: got V=%0b O=%0b want V=0 O=0", Valid, Overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    Ack = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      exp_q.push_back(n);
      drive_run(n);
      exp_len = exp_q.pop_front();
      n_checks++;
      if (Valid !== 1'b1 || RunLen !== 8'(exp_len)) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got V=%0b R=%0d want V=1 R=%0d",
                 n, Valid, RunLen, exp_len);
      end
    end
    Ack = 1'b0;
    n_checks++;
    if (EventCount !== 16'd4 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_count: got E=%0d O=%0b want E=4 O=0", EventCount, Overflow);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    z = 1'b1;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    n_checks++;
    if ({Valid, RunLen, EventCount, Busy, Overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun: got V=%0b R=%0d E=%0d B=%0b O=%0b want all 0",
               Valid, RunLen, EventCount, Busy, Overflow);
    end
    Reset = 1'b0; z = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (Valid !== 1'b0 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun_after: got V=%0b O=%0b want V=0 O=0", Valid, Overflow);
    end
  endtask

  task automatic test_count_wrap();
    Reset2 = 1'b1; z2 = 1'b0; Ack2 = 1'b1;
    tick();
    Reset2 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      z2 = 1'b1; tick();
      z2 = 1'b0; tick();
      if (i == 15) begin
        n_checks++;
        if (EventCount2 !== 4'd15) begin
          n_fail++;
          $display("FAIL wrap_before: got E=%0d want 15", EventCount2);
        end
      end
    end
    n_checks++;
    if (EventCount2 !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_after: got E=%0d want 0", EventCount2);
    end
  endtask

`ifdef ZRUN_ALARM_EN
  task automatic test_alarm();
    do_reset();
    z = 1'b1;
    repeat (15) tick();
    n_checks++;
    if (Alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_early: got %0b want 0 after 15 edges", Alarm);
    end
    tick();
    n_checks++;
    if (Alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_rise: got %0b want 1 at edge 16", Alarm);
    end
    repeat (4) tick();
    n_checks++;
    if (Alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_hold: got %0b want 1 at edge 20", Alarm);
    end
    z = 1'b0;
    tick();
    n_checks++;
    if (Alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_fall: got %0b want 0 after run end", Alarm);
    end
  endtask
`endif

  initial begin
    Reset = 1'b1; z = 1'b0; Ack = 1'b0;
    Reset2 = 1'b1; z2 = 1'b0; Ack2 = 1'b0;
    test_reset();
    test_single_run();
    test_overflow();
    test_saturation();
    test_ack_reload();
    test_back_to_back();
    test_reset_midrun();
    test_count_wrap();
`ifdef ZRUN_ALARM_EN
    test_alarm();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
